// File: rtl/lcd_ctrl_param.sv
// Parametrised image-window controller: loads an image from IROM,
// applies 2x2 window commands, and streams the buffer back to IRAM.
module lcd_ctrl_param #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int DW    = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [3:0]                       cmd,
  input  logic                             cmd_valid,
  input  logic [DW-1:0]                    IROM_Q,
  output logic                             IROM_rd,
  output logic [$clog2(IMG_W*IMG_H)-1:0]   IROM_A,
  output logic                             IRAM_valid,
  output logic [DW-1:0]                    IRAM_D,
  output logic [$clog2(IMG_W*IMG_H)-1:0]   IRAM_A,
  output logic                             busy,
  output logic                             done
);

  localparam int N  = IMG_W * IMG_H;
  localparam int AW = $clog2(N);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = AW - XW;

  localparam logic [AW-1:0] LAST  = AW'(N - 1);
  localparam logic [AW-1:0] ROW   = AW'(IMG_W);
  localparam logic [XW-1:0] X0    = XW'(IMG_W / 2 - 1);
  localparam logic [YW-1:0] Y0    = YW'(IMG_H / 2 - 1);
  localparam logic [XW-1:0] X_MAX = XW'(IMG_W - 2);
  localparam logic [YW-1:0] Y_MAX = YW'(IMG_H - 2);

  typedef enum logic [2:0] {
    S_INIT,
    S_LOAD,
    S_IDLE,
    S_EXEC,
    S_WRITE,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [DW-1:0] mem [N];

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;

  logic [AW-1:0] p0, p1, p2, p3;
  logic [DW-1:0] v0, v1, v2, v3;
  logic [DW-1:0] n0, n1, n2, n3;
  logic [DW-1:0] mx01, mx23, mx;
  logic [DW-1:0] mn01, mn23, mn;
  logic [DW+1:0] sum;
  logic [DW-1:0] avg;
  logic [AW-1:0] wr_nxt;
  logic          accept;
  logic          win_we;

  // Width is a power of two, so the origin address is just {y, x}.
  assign p0 = {y_q, x_q};
  assign p1 = p0 + 1'b1;
  assign p2 = p0 + ROW;
  assign p3 = p2 + 1'b1;

  assign v0 = mem[p0];
  assign v1 = mem[p1];
  assign v2 = mem[p2];
  assign v3 = mem[p3];

  assign mx01 = (v0 > v1) ? v0 : v1;
  assign mx23 = (v2 > v3) ? v2 : v3;
  assign mx   = (mx01 > mx23) ? mx01 : mx23;
  assign mn01 = (v0 < v1) ? v0 : v1;
  assign mn23 = (v2 < v3) ? v2 : v3;
  assign mn   = (mn01 < mn23) ? mn01 : mn23;

  assign sum = {2'b00, v0} + {2'b00, v1}
             + {2'b00, v2} + {2'b00, v3};
  assign avg = DW'(sum >> 2);

  assign wr_nxt = IRAM_A + 1'b1;
  assign accept = (state_q == S_IDLE) && cmd_valid
               && (cmd != 4'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_INIT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:  state_d = S_LOAD;
      S_LOAD:  if (IROM_A == LAST) state_d = S_IDLE;
      S_IDLE: begin
        if (cmd_valid)
          state_d = (cmd == 4'd0) ? S_WRITE : S_EXEC;
      end
      S_EXEC:  state_d = S_IDLE;
      S_WRITE: if (IRAM_A == LAST) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_INIT;
    endcase
  end

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    n0     = v0;
    n1     = v1;
    n2     = v2;
    n3     = v3;
    win_we = 1'b0;
    if (accept) begin
      case (cmd)
        4'd1: if (y_q != '0)    y_d = y_q - 1'b1;
        4'd2: if (y_q < Y_MAX)  y_d = y_q + 1'b1;
        4'd3: if (x_q != '0)    x_d = x_q - 1'b1;
        4'd4: if (x_q < X_MAX)  x_d = x_q + 1'b1;
        4'd5: begin
          win_we = 1'b1;
          n0 = mx; n1 = mx; n2 = mx; n3 = mx;
        end
        4'd6: begin
          win_we = 1'b1;
          n0 = mn; n1 = mn; n2 = mn; n3 = mn;
        end
        4'd7: begin
          win_we = 1'b1;
          n0 = avg; n1 = avg; n2 = avg; n3 = avg;
        end
        4'd8: begin
          win_we = 1'b1;
          n0 = v1; n1 = v3; n2 = v0; n3 = v2;
        end
        4'd9: begin
          win_we = 1'b1;
          n0 = v2; n1 = v0; n2 = v3; n3 = v1;
        end
        4'd10: begin
          win_we = 1'b1;
          n0 = v2; n1 = v3; n2 = v0; n3 = v1;
        end
        4'd11: begin
          win_we = 1'b1;
          n0 = v1; n1 = v0; n2 = v3; n3 = v2;
        end
        4'd12: begin
          x_d = X0;
          y_d = Y0;
        end
        default: ;
      endcase
    end
  end

  // Buffer has no reset; contents are only meaningful after a load.
  always_ff @(posedge clk) begin
    if (state_q == S_LOAD) begin
      mem[IROM_A] <= IROM_Q;
    end else if (win_we) begin
      mem[p0] <= n0;
      mem[p1] <= n1;
      mem[p2] <= n2;
      mem[p3] <= n3;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q        <= X0;
      y_q        <= Y0;
      busy       <= 1'b1;
      done       <= 1'b0;
      IROM_rd    <= 1'b0;
      IROM_A     <= '0;
      IRAM_valid <= 1'b0;
      IRAM_A     <= '0;
      IRAM_D     <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      case (state_q)
        S_INIT: begin
          IROM_rd <= 1'b1;
          IROM_A  <= '0;
        end
        S_LOAD: begin
          if (IROM_A == LAST) begin
            IROM_rd <= 1'b0;
            IROM_A  <= '0;
            busy    <= 1'b0;
          end else begin
            IROM_A  <= IROM_A + 1'b1;
          end
        end
        S_IDLE: begin
          if (cmd_valid) begin
            busy <= 1'b1;
            if (cmd == 4'd0) begin
              IRAM_valid <= 1'b1;
              IRAM_A     <= '0;
              IRAM_D     <= mem['0];
            end
          end
        end
        S_EXEC: busy <= 1'b0;
        S_WRITE: begin
          if (IRAM_A == LAST) begin
            IRAM_valid <= 1'b0;
            done       <= 1'b1;
          end else begin
            IRAM_A <= wr_nxt;
            IRAM_D <= mem[wr_nxt];
          end
        end
        S_DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_ctrl_param.sv
// Bench for lcd_ctrl_param: 8x8 instance checked against an image model,
// plus a 16x4 instance with hand-computed write-back expectations.
module tb_lcd_ctrl_param;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b0;
  logic [3:0] cmd = '0;
  logic       cmd_valid = 1'b0;
  logic [7:0] IROM_Q;
  logic       IROM_rd;
  logic [5:0] IROM_A;
  logic       IRAM_valid;
  logic [7:0] IRAM_D;
  logic [5:0] IRAM_A;
  logic       busy;
  logic       done;

  logic       reset_b = 1'b0;
  logic [3:0] cmd_b = '0;
  logic       cmd_valid_b = 1'b0;
  logic [7:0] IROM_Q_b;
  logic       IROM_rd_b;
  logic [5:0] IROM_A_b;
  logic       IRAM_valid_b;
  logic [7:0] IRAM_D_b;
  logic [5:0] IRAM_A_b;
  logic       busy_b;
  logic       done_b;

  assign IROM_Q   = {2'b00, IROM_A};
  assign IROM_Q_b = {2'b00, IROM_A_b};

  lcd_ctrl_param dut (
    .clk(clk), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid),
    .IROM_Q(IROM_Q), .IROM_rd(IROM_rd), .IROM_A(IROM_A),
    .IRAM_valid(IRAM_valid), .IRAM_D(IRAM_D), .IRAM_A(IRAM_A),
    .busy(busy), .done(done)
  );

  lcd_ctrl_param #(.IMG_W(16), .IMG_H(4), .DW(8)) dut_b (
    .clk(clk), .reset(reset_b), .cmd(cmd_b), .cmd_valid(cmd_valid_b),
    .IROM_Q(IROM_Q_b), .IROM_rd(IROM_rd_b), .IROM_A(IROM_A_b),
    .IRAM_valid(IRAM_valid_b), .IRAM_D(IRAM_D_b), .IRAM_A(IRAM_A_b),
    .busy(busy_b), .done(done_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Image model: plain array plus window coordinates.
  int img [64];
  int wx, wy;

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) img[i] = i;
    wx = 3;
    wy = 3;
  endfunction

  task automatic model_cmd(input int c);
    int a, b, d, e, va, vb, vd, ve, r;
    a = wy * 8 + wx; b = a + 1; d = a + 8; e = a + 9;
    va = img[a]; vb = img[b]; vd = img[d]; ve = img[e];
    case (c)
      1: if (wy > 0) wy--;
      2: if (wy < 6) wy++;
      3: if (wx > 0) wx--;
      4: if (wx < 6) wx++;
      5: begin
        r = va;
        if (vb > r) r = vb;
        if (vd > r) r = vd;
        if (ve > r) r = ve;
        img[a] = r; img[b] = r; img[d] = r; img[e] = r;
      end
      6: begin
        r = va;
        if (vb < r) r = vb;
        if (vd < r) r = vd;
        if (ve < r) r = ve;
        img[a] = r; img[b] = r; img[d] = r; img[e] = r;
      end
      7: begin
        r = (va + vb + vd + ve) / 4;
        img[a] = r; img[b] = r; img[d] = r; img[e] = r;
      end
      8: begin img[a] = vb; img[b] = ve; img[d] = va; img[e] = vd; end
      9: begin img[a] = vd; img[b] = va; img[d] = ve; img[e] = vb; end
      10: begin img[a] = vd; img[b] = ve; img[d] = va; img[e] = vb; end
      11: begin img[a] = vb; img[b] = va; img[d] = ve; img[e] = vd; end
      12: begin wx = 3; wy = 3; end
      default: ;
    endcase
  endtask

  // Compare process: load addresses and every write-back beat.
  int beat = 0;
  int ld = 0;
  int done_cnt = 0;
  int got [64];

  always @(negedge clk) begin
    if (!reset) begin
      beat = 0;
      ld = 0;
    end else begin
      if (IROM_rd) begin
        chk("irom_a", 32'(IROM_A), ld);
        ld++;
      end
      if (IRAM_valid) begin
        chk("iram_a", 32'(IRAM_A), beat);
        if (beat < 64) chk("iram_d", 32'(IRAM_D), img[beat]);
        got[IRAM_A] = int'(IRAM_D);
        beat++;
      end
      if (done) begin
        chk("done_len", beat, 64);
        beat = 0;
        done_cnt++;
      end
    end
  end

  int got_b [64];
  always @(negedge clk) begin
    if (reset_b && IRAM_valid_b) got_b[IRAM_A_b] = int'(IRAM_D_b);
  end

  task automatic do_reset();
    int rd_cnt;
    bit ok;
    reset = 1'b0;
    cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1);
    chk("rst_done", done, 0);
    chk("rst_rd", IROM_rd, 0);
    chk("rst_irom_a", 32'(IROM_A), 0);
    chk("rst_valid", IRAM_valid, 0);
    chk("rst_iram_a", 32'(IRAM_A), 0);
    chk("rst_iram_d", 32'(IRAM_D), 0);
    reset = 1'b1;
    model_reset();
    rd_cnt = 0;
    ok = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      #1;
      if (IROM_rd) rd_cnt++;
      if (!busy) begin ok = 1; break; end
    end
    chk("load_timeout", ok, 1);
    chk("load_len", rd_cnt, 64);
    chk("load_addrs", ld, 64);
  endtask

  task automatic wait_done(input string name);
    bit ok;
    ok = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      #1;
      if (done) begin ok = 1; break; end
    end
    chk(name, ok, 1);
    @(posedge clk);
    #1;
    chk("done_pulse", done, 0);
    chk("idle_after_done", busy, 0);
  endtask

  task automatic issue(input int c);
    cmd = 4'(c);
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    model_cmd(c);
    chk("busy_accept", busy, 1);
    if (c != 0) begin
      @(posedge clk);
      #1;
      chk("exec_one_cycle", busy, 0);
    end else begin
      wait_done("write_timeout");
    end
  endtask

  task automatic issue_b(input int c);
    bit ok;
    cmd_b = 4'(c);
    cmd_valid_b = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid_b = 1'b0;
    if (c != 0) begin
      @(posedge clk);
      #1;
    end else begin
      ok = 0;
      for (int k = 0; k < 200; k++) begin
        @(posedge clk);
        #1;
        if (done_b) begin ok = 1; break; end
      end
      chk("b_write_timeout", ok, 1);
      @(posedge clk);
      #1;
    end
    chk("b_idle", busy_b, 0);
  endtask

  initial begin
    int dc;
    bit ok;

    // 1: plain load and write-back of the ramp
    do_reset();
    dc = done_cnt;
    issue(0);
    for (int i = 0; i < 64; i++) chk("ramp", got[i], i);
    chk("done_count1", done_cnt - dc, 1);

    // 2: max, avg, min on the default window
    do_reset();
    issue(5); issue(0);
    chk("max27", got[27], 36); chk("max28", got[28], 36);
    chk("max35", got[35], 36); chk("max36", got[36], 36);
    do_reset();
    issue(7); issue(0);
    chk("avg27", got[27], 31); chk("avg36", got[36], 31);
    chk("avg26", got[26], 26);
    do_reset();
    issue(6); issue(0);
    chk("min28", got[28], 27); chk("min35", got[35], 27);

    // 3: boundary moves, origin reset, mirror Y
    do_reset();
    repeat (4) issue(1);
    repeat (4) issue(3);
    issue(5);
    issue(12);
    issue(11);
    issue(0);
    chk("corner0", got[0], 9); chk("corner1", got[1], 9);
    chk("corner8", got[8], 9); chk("corner9", got[9], 9);
    chk("corner2", got[2], 2);
    chk("my27", got[27], 28); chk("my28", got[28], 27);
    chk("my35", got[35], 36); chk("my36", got[36], 35);

    // 4: rotate CW then CCW, back-to-back write-backs
    do_reset();
    issue(9); issue(0);
    chk("cw27", got[27], 35); chk("cw28", got[28], 27);
    chk("cw35", got[35], 36); chk("cw36", got[36], 28);
    issue(8);
    dc = done_cnt;
    issue(0);
    chk("ccw27", got[27], 27); chk("ccw36", got[36], 36);
    issue(0);
    chk("ccw35", got[35], 35);
    chk("done_count2", done_cnt - dc, 2);

    // 5: held cmd_valid accepts every other cycle
    do_reset();
    cmd = 4'd4;
    cmd_valid = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      chk("hold_busy", busy, (k % 2));
    end
    cmd_valid = 1'b0;
    repeat (3) model_cmd(4);
    issue(5);
    issue(0);
    chk("hold30", got[30], 39); chk("hold39", got[39], 39);
    chk("hold29", got[29], 29);
    // cmd_valid pulses during write-back are ignored
    cmd = 4'd0;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    cmd = 4'd5;
    cmd_valid = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    wait_done("pulse_write_timeout");
    chk("pulse22", got[22], 22);

    // 6: reset in the middle of write-back
    cmd = 4'd0;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("beat20_addr", 32'(IRAM_A), 20);
    reset = 1'b0;
    #1;
    chk("abort_valid", IRAM_valid, 0);
    chk("abort_busy", busy, 1);
    do_reset();
    issue(0);
    chk("reload30", got[30], 30);

    // 16x4 instance: origin 23, down clamps at y=2
    reset_b = 1'b1;
    ok = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      #1;
      if (!busy_b) begin ok = 1; break; end
    end
    chk("b_load_timeout", ok, 1);
    issue_b(5);
    issue_b(0);
    chk("b23", got_b[23], 40); chk("b24", got_b[24], 40);
    chk("b39", got_b[39], 40); chk("b40", got_b[40], 40);
    chk("b22", got_b[22], 22); chk("b41", got_b[41], 41);
    repeat (3) issue_b(2);
    issue_b(5);
    issue_b(0);
    chk("b39y2", got_b[39], 56); chk("b55", got_b[55], 56);
    chk("b56", got_b[56], 56); chk("b23y2", got_b[23], 40);
    chk("b57", got_b[57], 57);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_ctrl_param.md
Name: lcd_ctrl_param

Overview:
Parametrised image-window controller. It loads an IMG_W x IMG_H image of DW-bit pixels from IROM into an internal buffer. It then applies host commands to a 2x2 operation window and streams the buffer to IRAM on request. This block is the next generation of the fixed 8x8 LCD controller in this design. Its new features are a configurable image size and pixel width, a correct pixel-value average, an origin-reset command, and repeatable write-back (it returns to command mode after each write, instead of halting).

Parameters:
IMG_W, 8, image width in pixels (power of two, >=2)
IMG_H, 8, image height in pixels (>=2)
DW, 8, pixel width in bits
(localparam AW = clog2(IMG_W*IMG_H), the buffer address width)

Ports:
clk  input  1  clock; all logic on the rising edge
reset  input  1  asynchronous, active-low reset
cmd  input  4  command code
cmd_valid  input  1  command strobe; sampled only while busy=0
IROM_Q  input  DW  ROM read data; combinational, valid in the same cycle as IROM_A
IROM_rd  output  1  ROM read enable
IROM_A  output  AW  ROM address
IRAM_valid  output  1  RAM write strobe
IRAM_D  output  DW  RAM write data
IRAM_A  output  AW  RAM write address
busy  output  1  1 = command not accepted
done  output  1  one-cycle pulse at the end of each write-back

Behaviour:
- All outputs are registered. While reset=0: state=INIT, busy=1, done=0, IROM_rd=0, IROM_A=0, IRAM_valid=0, IRAM_A=0, IRAM_D=0, window origin = (x=IMG_W/2-1, y=IMG_H/2-1). Buffer contents are undefined.
- Window origin P0 = y*IMG_W+x, with x in 0..IMG_W-2 and y in 0..IMG_H-2. The other window pixels are P1=P0+1, P2=P0+IMG_W, P3=P0+IMG_W+1.
- States: INIT, LOAD, IDLE, EXEC, WRITE, DONE.
- INIT: the first edge after reset release goes to LOAD with IROM_rd=1 and IROM_A=0.
- LOAD: each edge stores buf[IROM_A] <= IROM_Q and increments IROM_A. The edge that stores address N-1 (N=IMG_W*IMG_H) goes to IDLE with IROM_rd=0, IROM_A=0, busy=0. IROM_rd is therefore high for exactly N cycles.
- IDLE: busy=0. An edge with cmd_valid=1 accepts cmd:
  - cmd 0 goes to WRITE.
  - Any other cmd is executed on that edge and goes to EXEC (busy=1 for exactly one cycle), then back to IDLE.
  - cmd_valid while busy=1 is ignored and not queued.
- Commands:
  - 1 up: y-1 if y>0.
  - 2 down: y+1 if y<IMG_H-2.
  - 3 left: x-1 if x>0.
  - 4 right: x+1 if x<IMG_W-2.
  - A move at a boundary is a no-op. It still costs one EXEC cycle.
  - 5 max: all four window pixels <= max of the four values.
  - 6 min: all four window pixels <= min of the four values.
  - 7 avg: all four window pixels <= floor((v0+v1+v2+v3)/4). The sum is DW+2 bits wide with no overflow. The operands are pixel values, not addresses.
  - 8 CCW: P0<=P1, P1<=P3, P2<=P0, P3<=P2.
  - 9 CW: P0<=P2, P1<=P0, P2<=P3, P3<=P1.
  - 10 mirror X: swap P0/P2 and P1/P3.
  - 11 mirror Y: swap P0/P1 and P2/P3.
  - 12 origin reset: window returns to its reset origin; the buffer is unchanged.
  - 13-15: no-op (one EXEC cycle).
- Commands 8-11 are simultaneous permutations: every read uses pre-edge values.
- WRITE: on the entry edge, IRAM_valid=1, IRAM_A=0, IRAM_D=buf[0]. Each following edge advances IRAM_A by 1 and sets IRAM_D=buf[IRAM_A]. This gives N consecutive beats, one per cycle, with no gaps.
- The edge after beat N-1 goes to DONE: IRAM_valid=0, done=1, busy=1. The next edge goes to IDLE with done=0. The buffer and window are preserved, so further commands and write-backs are legal.
- Reset asserted in any state (including mid-LOAD or mid-WRITE) takes effect immediately: outputs take their reset values, and after release the full load restarts from address 0.

Test Plan:
1. Default params, ROM pixel[i]=i. Release reset -> IROM_rd high for 64 cycles, addresses 0..63, then busy=0. Issue cmd 0 -> 64 IRAM beats with IRAM_A=i and IRAM_D=i, then done=1 for one cycle, then busy=0.
2. After load, cmd 5 -> write-back shows addresses 27,28,35,36 = 36. Reload, then cmd 7 -> those four = 31 ((27+28+35+36)/4). Reload, then cmd 6 -> those four = 27.
3. Boundary: cmd 1 x4 -> y=0, and the 4th move is a no-op (busy still high one cycle). Then cmd 3 x4 -> x=0. Then cmd 5 -> addresses 0,1,8,9 = 9. Then cmd 12 and cmd 11 -> address 27=28, address 28=27, address 35=36, address 36=35.
4. Cmd 9 at the origin -> address 27=35, 28=27, 35=36, 36=28. Then cmd 8 -> original ramp restored. Two consecutive cmd 0 sequences -> two identical streams and two done pulses.
5. cmd_valid held high with cmd 4 continuously -> one move accepted every 2 cycles. Pulsing cmd_valid during WRITE -> ignored, and the stream is unchanged.
6. Drive reset=0 at beat 20 of WRITE -> IRAM_valid=0 and busy=1 immediately. After release, reload from address 0. With IMG_W=16, IMG_H=4: origin is address 23 (x=7, y=1), and cmd 2 x3 stops at y=2.
